// File: rtl/ex_mem_pipe.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe
//   EX/MEM pipeline register with a valid/ready handshake and a two-entry
//   skid buffer. At capture it resolves beq/bne and computes the jump target,
//   so MEM sees the branch decision and target without the raw flags.
//
// Ports
//   clk                  clock, all state updates on the rising edge
//   rst_n                synchronous reset, ACTIVE-HIGH despite the name
//   flush_i              drop every held entry and any input this cycle
//   in_valid_i/in_ready_o  EX-side handshake (in_ready_o is registered)
//   zero_i .. iowrite_i  EX control bits and ALU zero flag
//   alu_result_i, imme_i, pc_i, rdata2_i, rd_i   EX datapath
//   out_valid_o/out_ready_i  MEM-side handshake
//   regwrite_o .. iowrite_o, branch_taken_o   controls, forced 0 when empty
//   addr_jump_o, alu_result_o, rdata2_o, rd_o  data, held when empty
//   occupancy_o          number of entries held (0..2)
// ----------------------------------------------------------------------------
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              zero_i,
  input  logic              regwrite_i,
  input  logic              branch_i,
  input  logic              branch_ne_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic              memoriotoreg_i,
  input  logic              ioread_i,
  input  logic              iowrite_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] imme_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rdata2_i,
  input  logic [RA_W-1:0]   rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              regwrite_o,
  output logic              memread_o,
  output logic              memwrite_o,
  output logic              memoriotoreg_o,
  output logic              ioread_o,
  output logic              iowrite_o,
  output logic              branch_taken_o,
  output logic [ADDR_W-1:0] addr_jump_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [RA_W-1:0]   rd_o,
  output logic [1:0]        occupancy_o
);

  // Control bit order inside an entry: {regwrite, memread, memwrite,
  // memoriotoreg, ioread, iowrite}.
  localparam int CTRL_W = 6;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              taken;
    logic [ADDR_W-1:0] jump;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata2;
    logic [RA_W-1:0]   rd;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  // Only the low ADDR_W immediate bits matter for the wrapped target.
  logic unused_imme_hi;
  assign unused_imme_hi = ^imme_i[DATA_W-1:ADDR_W];

  // Capture-time branch resolution; the sum wraps at ADDR_W bits.
  always_comb begin
    in_entry        = '0;
    in_entry.ctrl   = {regwrite_i, memread_i, memwrite_i,
                       memoriotoreg_i, ioread_i, iowrite_i};
    in_entry.taken  = (branch_i & zero_i) | (branch_ne_i & ~zero_i);
    in_entry.jump   = pc_i + imme_i[ADDR_W-1:0];
    in_entry.alu    = alu_result_i;
    in_entry.rdata2 = rdata2_i;
    in_entry.rd     = rd_i;
  end

  // in_ready depends only on registered state, so MEM's ready never
  // reaches back to EX combinationally.
  assign in_ready_o = ~skid_valid_q;
  assign accept     = in_valid_i & in_ready_o;
  assign pop        = main_valid_q & out_ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      // Flush beats accept and pop; payload registers keep their contents
      // so the data outputs hold.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (!main_valid_q || pop) begin
        if (skid_valid_q) begin
          // Oldest entry first: skid always precedes any new input.
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d       = in_entry;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      // Park the input only when main is busy and stays busy.
      if (accept && main_valid_q && !pop && !skid_valid_q) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Controls read 0 whenever the main entry is empty.
  logic [CTRL_W-1:0] ctrl_gated;
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
      assign ctrl_gated[gi] = main_q.ctrl[gi] & main_valid_q;
    end
  endgenerate

  assign regwrite_o     = ctrl_gated[5];
  assign memread_o      = ctrl_gated[4];
  assign memwrite_o     = ctrl_gated[3];
  assign memoriotoreg_o = ctrl_gated[2];
  assign ioread_o       = ctrl_gated[1];
  assign iowrite_o      = ctrl_gated[0];
  assign branch_taken_o = main_q.taken & main_valid_q;

  assign out_valid_o  = main_valid_q;
  assign addr_jump_o  = main_q.jump;
  assign alu_result_o = main_q.alu;
  assign rdata2_o     = main_q.rdata2;
  assign rd_o         = main_q.rd;
  assign occupancy_o  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        zero_i, regwrite_i, branch_i, branch_ne_i, memread_i;
  logic        memwrite_i, memoriotoreg_i, ioread_i, iowrite_i;
  logic [31:0] alu_result_i, imme_i, rdata2_i;
  logic [13:0] pc_i;
  logic [4:0]  rd_i;
  logic        out_valid_o, out_ready_i;
  logic        regwrite_o, memread_o, memwrite_o, memoriotoreg_o, ioread_o, iowrite_o;
  logic        branch_taken_o;
  logic [13:0] addr_jump_o;
  logic [31:0] alu_result_o, rdata2_o;
  logic [4:0]  rd_o;
  logic [1:0]  occupancy_o;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .zero_i(zero_i), .regwrite_i(regwrite_i), .branch_i(branch_i),
    .branch_ne_i(branch_ne_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .memoriotoreg_i(memoriotoreg_i), .ioread_i(ioread_i), .iowrite_i(iowrite_i),
    .alu_result_i(alu_result_i), .imme_i(imme_i), .pc_i(pc_i),
    .rdata2_i(rdata2_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .memoriotoreg_o(memoriotoreg_o), .ioread_o(ioread_o), .iowrite_o(iowrite_o),
    .branch_taken_o(branch_taken_o), .addr_jump_o(addr_jump_o),
    .alu_result_o(alu_result_o), .rdata2_o(rdata2_o), .rd_o(rd_o),
    .occupancy_o(occupancy_o)
  );

  // Reference model: a FIFO of at most two instructions, plus the last
  // entry that was at the head (the data outputs hold it when empty).
  typedef struct {
    logic [5:0]  ctrl;   // {regwrite, memread, memwrite, memoriotoreg, ioread, iowrite}
    logic        taken;
    logic [13:0] jump;
    logic [31:0] alu;
    logic [31:0] rdata2;
    logic [4:0]  rd;
  } ent_t;

  ent_t model_q[$];
  ent_t last_head;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk_entry();
    ent_t e;
    int   sum;
    e.ctrl   = {regwrite_i, memread_i, memwrite_i, memoriotoreg_i, ioread_i, iowrite_i};
    e.taken  = (branch_i && zero_i) || (branch_ne_i && !zero_i);
    sum      = int'(pc_i) + int'(imme_i);
    e.jump   = 14'(sum % 16384);
    e.alu    = alu_result_i;
    e.rdata2 = rdata2_i;
    e.rd     = rd_i;
    return e;
  endfunction

  task automatic check_outputs();
    logic v;
    v = (model_q.size() > 0);
    chk("out_valid", 64'(out_valid_o), 64'(v));
    chk("occupancy", 64'(occupancy_o), 64'(model_q.size()));
    chk("in_ready", 64'(in_ready_o), 64'(model_q.size() < 2));
    chk("ctrl", 64'({regwrite_o, memread_o, memwrite_o, memoriotoreg_o, ioread_o, iowrite_o}),
        64'(v ? last_head.ctrl : 6'd0));
    chk("branch_taken", 64'(branch_taken_o), 64'(v & last_head.taken));
    chk("addr_jump", 64'(addr_jump_o), 64'(last_head.jump));
    chk("alu_result", 64'(alu_result_o), 64'(last_head.alu));
    chk("rdata2", 64'(rdata2_o), 64'(last_head.rdata2));
    chk("rd", 64'(rd_o), 64'(last_head.rd));
  endtask

  // One clock: advance the model from the current inputs, then compare.
  task automatic step();
    bit acc, pp;
    if (rst_n) begin
      model_q.delete();
      last_head = '{default: '0};
    end else if (flush_i) begin
      model_q.delete();
    end else begin
      acc = in_valid_i && (model_q.size() < 2);
      pp  = (model_q.size() > 0) && out_ready_i;
      if (pp) void'(model_q.pop_front());
      if (acc) model_q.push_back(mk_entry());
    end
    @(posedge clk);
    #1;
    if (model_q.size() > 0) last_head = model_q[0];
    check_outputs();
  endtask

  task automatic drive(input logic [31:0] alu, input logic [4:0] rd, input logic [5:0] ctrl,
                       input logic [13:0] pc, input logic [31:0] imme,
                       input logic br, input logic bne, input logic z, input logic [31:0] rd2);
    alu_result_i = alu; rd_i = rd;
    {regwrite_i, memread_i, memwrite_i, memoriotoreg_i, ioread_i, iowrite_i} = ctrl;
    pc_i = pc; imme_i = imme; branch_i = br; branch_ne_i = bne; zero_i = z; rdata2_i = rd2;
  endtask

  task automatic drive_rand();
    drive($urandom, 5'($urandom), 6'($urandom), 14'($urandom), $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), $urandom);
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
    logic [13:0] pc;
    logic [31:0] imme;
    logic        br, bne, z;
    logic [31:0] rd2;
    logic [13:0] exp_jump;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // alu, rd, ctrl, pc, imme, br, bne, z, rd2, expected jump, expected taken
    vecs[0] = '{32'h1234, 5'd7, 6'b100000, 14'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 14'h0000, 1'b0};
    vecs[1] = '{32'h5, 5'd1, 6'b000000, 14'h3FF0, 32'h20, 1'b1, 1'b0, 1'b1, 32'hAA, 14'h0010, 1'b1};
    vecs[2] = '{32'h6, 5'd2, 6'b010100, 14'h3FF0, 32'h20, 1'b0, 1'b1, 1'b1, 32'hBB, 14'h0010, 1'b0};
    vecs[3] = '{32'h7, 5'd3, 6'b001000, 14'h0100, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'hCC, 14'h00FC, 1'b1};
    vecs[4] = '{32'h8, 5'd31, 6'b000011, 14'h0005, 32'h3, 1'b1, 1'b0, 1'b0, 32'hDD, 14'h0008, 1'b0};

    last_head = '{default: '0};
    rst_n = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    drive(32'h0, 5'd0, 6'd0, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    step();
    rst_n = 1'b0;
    step();

    // Table: back-to-back single passes with MEM always ready.
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].alu, vecs[i].rd, vecs[i].ctrl, vecs[i].pc, vecs[i].imme,
            vecs[i].br, vecs[i].bne, vecs[i].z, vecs[i].rd2);
      in_valid_i = 1'b1;
      step();
      chk("tbl_jump", 64'(addr_jump_o), 64'(vecs[i].exp_jump));
      chk("tbl_taken", 64'(branch_taken_o), 64'(vecs[i].exp_taken));
      chk("tbl_alu", 64'(alu_result_o), 64'(vecs[i].alu));
      chk("tbl_rd", 64'(rd_o), 64'(vecs[i].rd));
      chk("tbl_occ", 64'(occupancy_o), 64'd1);
      $display("vec %0d: alu=%0h rd=%0d jump=%0h taken=%0b", i, alu_result_o, rd_o,
               addr_jump_o, branch_taken_o);
    end
    in_valid_i = 1'b0;
    step();

    // Stall fill: A, B captured; C refused; then drained in order.
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    drive(32'hA, 5'd10, 6'b100000, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    drive(32'hB, 5'd11, 6'b100000, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    drive(32'hC, 5'd12, 6'b100000, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    chk("fill_occ", 64'(occupancy_o), 64'd2);
    chk("fill_ready", 64'(in_ready_o), 64'd0);
    chk("fill_head", 64'(alu_result_o), 64'hA);
    out_ready_i = 1'b1;
    step(); chk("drain_b", 64'(alu_result_o), 64'hB);
    step(); chk("drain_c", 64'(alu_result_o), 64'hC);
    in_valid_i = 1'b0;
    step(); chk("drain_empty", 64'(out_valid_o), 64'd0);
    $display("stall fill/drain sequence done");

    // Flush while full with a new input present.
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    drive(32'h11, 5'd1, 6'b001000, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    drive(32'h22, 5'd2, 6'b001000, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    drive(32'h33, 5'd3, 6'b001000, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    flush_i = 1'b1; step();
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_memwrite", 64'(memwrite_o), 64'd0);
    chk("flush_occ", 64'(occupancy_o), 64'd0);
    chk("flush_ready", 64'(in_ready_o), 64'd1);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    step(); chk("flush_dropped", 64'(out_valid_o), 64'd0);
    $display("flush sequence done");

    // Reset while full and stalled, then a normal pass.
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    drive(32'h44, 5'd4, 6'b111111, 14'h10, 32'h4, 1'b1, 1'b0, 1'b1, 32'h9); step();
    drive(32'h55, 5'd5, 6'b111111, 14'h10, 32'h4, 1'b1, 1'b0, 1'b1, 32'h9); step();
    rst_n = 1'b1; step();
    chk("rst_alu", 64'(alu_result_o), 64'd0);
    chk("rst_jump", 64'(addr_jump_o), 64'd0);
    rst_n = 1'b0; out_ready_i = 1'b1;
    drive(32'h66, 5'd6, 6'b100000, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0); step();
    chk("post_rst_alu", 64'(alu_result_o), 64'h66);
    in_valid_i = 1'b0; step();
    $display("reset-while-full sequence done");

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      drive_rand();
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 39) == 0);
      rst_n       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    $display("random run done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
